ext_mem_sched: RTL and testbench

EXT_MEM_SCHED -- requirements
Module: ext_mem_sched

---
 rtl/mem_sched_pkg.sv | 27 ++
 rtl/ext_mem_beat_ctr.sv | 29 ++
 rtl/ext_mem_sched.sv | 225 ++++++++++++++++++++++
 tb/tb_ext_mem_sched.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sched_pkg.sv
// Shared types and sizes for the external memory scheduler.
// State encodings, requester ids, burst lengths and bus widths.
package mem_sched_pkg;

  localparam int BEAT_W  = 128;
  localparam int LINE_W  = 512;
  localparam int MASK_W  = 64;
  localparam int BMASK_W = 16;

  localparam logic [2:0] BURST_PTW  = 3'd1;
  localparam logic [2:0] BURST_LINE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_WR_RESP
  } state_t;

  typedef enum logic [1:0] {
    SRC_PTW,
    SRC_IC,
    SRC_DC
  } src_t;

endpackage

// File: rtl/ext_mem_beat_ctr.sv
// Beat index for read and write bursts.
// Decodes first and last beat for the active burst length.
module ext_mem_beat_ctr
  import mem_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  input  logic [2:0] burst,
  output logic [1:0] k,
  output logic       first,
  output logic       last
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k <= 2'd0;
    end else if (clr) begin
      k <= 2'd0;
    end else if (inc) begin
      k <= k + 2'd1;
    end
  end

  assign first = (k == 2'd0);
  assign last  = (k == 2'(burst - 3'd1));

endmodule

// File: rtl/ext_mem_sched.sv
// Arbitrates PTW, ICACHE and DCACHE onto one external memory port.
// One transaction in flight; PTW fixed priority, caches round-robin.
module ext_mem_sched
  import mem_sched_pkg::*;
#(
  parameter int PHY_ADDR_WIDTH = 34,
  parameter int RD_TIMEOUT     = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_flush,
  input  logic                      i_ptw_req,
  input  logic [PHY_ADDR_WIDTH-1:0] i_ptw_paddr,
  output logic                      o_ptw_gnt,
  output logic                      o_ptw_done,
  output logic [BEAT_W-1:0]         o_ptw_dat,
  input  logic                      i_icache_req,
  input  logic [PHY_ADDR_WIDTH-1:0] i_icache_paddr,
  output logic                      o_icache_gnt,
  output logic                      o_icache_done,
  output logic [LINE_W-1:0]         o_icache_dat,
  input  logic                      i_dcache_rden,
  input  logic                      i_dcache_wren,
  input  logic [PHY_ADDR_WIDTH-1:0] i_dcache_paddr,
  input  logic [LINE_W-1:0]         i_dcache_wdat,
  input  logic [MASK_W-1:0]         i_dcache_wmask,
  output logic                      o_dcache_gnt,
  output logic                      o_dcache_done,
  output logic [LINE_W-1:0]         o_dcache_dat,
  output logic                      o_ext_rden,
  output logic                      o_ext_wren,
  output logic [PHY_ADDR_WIDTH-1:0] o_ext_paddr,
  output logic [2:0]                o_ext_burst,
  output logic                      o_ext_burst_vld,
  output logic                      o_ext_burst_start,
  output logic                      o_ext_burst_end,
  output logic [BMASK_W-1:0]        o_ext_mask,
  output logic [BEAT_W-1:0]         o_ext_wdat,
  input  logic                      i_ext_rdy,
  input  logic                      i_ext_rd_ack,
  input  logic [BEAT_W-1:0]         i_ext_rdat,
  input  logic                      i_ext_wr_ack,
  output logic                      o_busy,
  output logic                      o_err
);

  state_t                    state;
  src_t                      src;
  logic                      is_wr;
  logic [PHY_ADDR_WIDTH-1:0] paddr;
  logic [LINE_W-1:0]         wdat;
  logic [MASK_W-1:0]         wmask;
  logic                      rr;
  logic                      sup;
  logic [7:0]                tmo;
  logic [1:0]                k;
  logic                      first;
  logic                      last;
  logic [2:0]                burst;

  logic idle, cmd, wr, kill, tmo_hit;
  logic ptw_ok, ic_ok, dc_any;
  logic pick_ptw, pick_ic, pick_dc;

  // rr = 0 favours ICACHE, rr = 1 favours DCACHE
  assign idle     = rst_n && (state == ST_IDLE);
  assign ptw_ok   = i_ptw_req && !i_flush;
  assign ic_ok    = i_icache_req && !i_flush;
  assign dc_any   = i_dcache_rden || i_dcache_wren;
  assign pick_ptw = idle && ptw_ok;
  assign pick_ic  = idle && !ptw_ok && ic_ok && (!rr || !dc_any);
  assign pick_dc  = idle && !ptw_ok && dc_any && (rr || !ic_ok);

  assign o_ptw_gnt    = pick_ptw;
  assign o_icache_gnt = pick_ic;
  assign o_dcache_gnt = pick_dc;

  assign cmd     = (state == ST_CMD);
  assign wr      = (state == ST_WR_DATA);
  assign burst   = (src == SRC_PTW) ? BURST_PTW : BURST_LINE;
  assign kill    = sup || i_flush;
  assign tmo_hit = (tmo == 8'(RD_TIMEOUT - 1));

  assign o_busy      = (state != ST_IDLE);
  assign o_ext_rden  = cmd && !is_wr;
  assign o_ext_wren  = cmd && is_wr;
  assign o_ext_paddr = cmd ? paddr : '0;
  assign o_ext_burst = cmd ? burst : '0;

  assign o_ext_burst_vld   = wr;
  assign o_ext_burst_start = wr && first;
  assign o_ext_burst_end   = wr && last;
  assign o_ext_wdat = wr ? wdat[int'(k)*BEAT_W +: BEAT_W] : '0;
  assign o_ext_mask = wr ? wmask[int'(k)*BMASK_W +: BMASK_W] : '0;

  ext_mem_beat_ctr u_beat (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == ST_IDLE || cmd),
    .inc   ((state == ST_RD_DATA && i_ext_rd_ack) || (wr && i_ext_rdy)),
    .burst (burst),
    .k     (k),
    .first (first),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      src           <= SRC_PTW;
      is_wr         <= 1'b0;
      paddr         <= '0;
      wdat          <= '0;
      wmask         <= '0;
      rr            <= 1'b0;
      sup           <= 1'b0;
      tmo           <= '0;
      o_ptw_dat     <= '0;
      o_icache_dat  <= '0;
      o_dcache_dat  <= '0;
      o_ptw_done    <= 1'b0;
      o_icache_done <= 1'b0;
      o_dcache_done <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      o_ptw_done    <= 1'b0;
      o_icache_done <= 1'b0;
      o_dcache_done <= 1'b0;
      o_err         <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          tmo <= '0;
          sup <= 1'b0;
          if (pick_ptw || pick_ic || pick_dc) begin
            state <= ST_CMD;
          end
          unique case (1'b1)
            pick_ptw: begin
              src   <= SRC_PTW;
              is_wr <= 1'b0;
              paddr <= i_ptw_paddr;
            end
            pick_ic: begin
              src   <= SRC_IC;
              is_wr <= 1'b0;
              paddr <= i_icache_paddr;
              rr    <= 1'b1;
            end
            pick_dc: begin
              src   <= SRC_DC;
              is_wr <= i_dcache_wren;
              paddr <= i_dcache_paddr;
              wdat  <= i_dcache_wdat;
              wmask <= i_dcache_wmask;
              rr    <= 1'b0;
            end
            default: ;
          endcase
        end
        ST_CMD: begin
          if (i_ext_rdy) begin
            tmo   <= '0;
            state <= is_wr ? ST_WR_DATA : ST_RD_DATA;
          end else if (tmo_hit) begin
            state <= ST_IDLE;
            o_err <= 1'b1;
          end else begin
            tmo <= tmo + 8'd1;
          end
        end
        ST_RD_DATA: begin
          if (i_ext_rd_ack) begin
            tmo <= '0;
            unique case (src)
              SRC_PTW: o_ptw_dat <= i_ext_rdat;
              SRC_IC:  o_icache_dat[int'(k)*BEAT_W +: BEAT_W] <= i_ext_rdat;
              default: o_dcache_dat[int'(k)*BEAT_W +: BEAT_W] <= i_ext_rdat;
            endcase
            if (last) begin
              state         <= ST_IDLE;
              o_ptw_done    <= (src == SRC_PTW) && !kill;
              o_icache_done <= (src == SRC_IC) && !kill;
              o_dcache_done <= (src == SRC_DC);
            end
          end else if (tmo_hit) begin
            state <= ST_IDLE;
            o_err <= 1'b1;
          end else begin
            tmo <= tmo + 8'd1;
          end
        end
        ST_WR_DATA: begin
          if (i_ext_rdy) begin
            tmo <= '0;
            if (last) begin
              state <= ST_WR_RESP;
            end
          end else if (tmo_hit) begin
            state <= ST_IDLE;
            o_err <= 1'b1;
          end else begin
            tmo <= tmo + 8'd1;
          end
        end
        ST_WR_RESP: begin
          if (i_ext_wr_ack) begin
            state         <= ST_IDLE;
            o_dcache_done <= 1'b1;
          end else if (tmo_hit) begin
            state <= ST_IDLE;
            o_err <= 1'b1;
          end else begin
            tmo <= tmo + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // a flushed PTW/ICACHE fill still drains the bus but reports nothing
      if (o_busy && i_flush && src != SRC_DC) begin
        sup <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ext_mem_sched.sv
// Directed bench for ext_mem_sched: arbitration table,
// then hand-timed read, write, flush, timeout and reset sequences.
module tb_ext_mem_sched;

  localparam int AW = 34;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           i_flush = 1'b0;
  logic           i_ptw_req = 1'b0;
  logic [AW-1:0]  i_ptw_paddr = '0;
  logic           o_ptw_gnt, o_ptw_done;
  logic [127:0]   o_ptw_dat;
  logic           i_icache_req = 1'b0;
  logic [AW-1:0]  i_icache_paddr = '0;
  logic           o_icache_gnt, o_icache_done;
  logic [511:0]   o_icache_dat;
  logic           i_dcache_rden = 1'b0;
  logic           i_dcache_wren = 1'b0;
  logic [AW-1:0]  i_dcache_paddr = '0;
  logic [511:0]   i_dcache_wdat = '0;
  logic [63:0]    i_dcache_wmask = '0;
  logic           o_dcache_gnt, o_dcache_done;
  logic [511:0]   o_dcache_dat;
  logic           o_ext_rden, o_ext_wren;
  logic [AW-1:0]  o_ext_paddr;
  logic [2:0]     o_ext_burst;
  logic           o_ext_burst_vld, o_ext_burst_start, o_ext_burst_end;
  logic [15:0]    o_ext_mask;
  logic [127:0]   o_ext_wdat;
  logic           i_ext_rdy = 1'b0;
  logic           i_ext_rd_ack = 1'b0;
  logic [127:0]   i_ext_rdat = '0;
  logic           i_ext_wr_ack = 1'b0;
  logic           o_busy, o_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ext_mem_sched #(
    .PHY_ADDR_WIDTH (AW),
    .RD_TIMEOUT     (255)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_flush           (i_flush),
    .i_ptw_req         (i_ptw_req),
    .i_ptw_paddr       (i_ptw_paddr),
    .o_ptw_gnt         (o_ptw_gnt),
    .o_ptw_done        (o_ptw_done),
    .o_ptw_dat         (o_ptw_dat),
    .i_icache_req      (i_icache_req),
    .i_icache_paddr    (i_icache_paddr),
    .o_icache_gnt      (o_icache_gnt),
    .o_icache_done     (o_icache_done),
    .o_icache_dat      (o_icache_dat),
    .i_dcache_rden     (i_dcache_rden),
    .i_dcache_wren     (i_dcache_wren),
    .i_dcache_paddr    (i_dcache_paddr),
    .i_dcache_wdat     (i_dcache_wdat),
    .i_dcache_wmask    (i_dcache_wmask),
    .o_dcache_gnt      (o_dcache_gnt),
    .o_dcache_done     (o_dcache_done),
    .o_dcache_dat      (o_dcache_dat),
    .o_ext_rden        (o_ext_rden),
    .o_ext_wren        (o_ext_wren),
    .o_ext_paddr       (o_ext_paddr),
    .o_ext_burst       (o_ext_burst),
    .o_ext_burst_vld   (o_ext_burst_vld),
    .o_ext_burst_start (o_ext_burst_start),
    .o_ext_burst_end   (o_ext_burst_end),
    .o_ext_mask        (o_ext_mask),
    .o_ext_wdat        (o_ext_wdat),
    .i_ext_rdy         (i_ext_rdy),
    .i_ext_rd_ack      (i_ext_rd_ack),
    .i_ext_rdat        (i_ext_rdat),
    .i_ext_wr_ack      (i_ext_wr_ack),
    .o_busy            (o_busy),
    .o_err             (o_err)
  );

  typedef struct packed {
    logic       ptw;
    logic       ic;
    logic       dr;
    logic       dw;
    logic       fl;
    logic [2:0] gnt;
  } arb_vec_t;

  arb_vec_t tv [10];

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic [127:0] beat(input logic [31:0] tag, input int k);
    return {4{tag + 32'(k)}};
  endfunction

  function automatic logic [511:0] line(input logic [31:0] tag);
    return {beat(tag, 3), beat(tag, 2), beat(tag, 1), beat(tag, 0)};
  endfunction

  function automatic logic [19:0] outs();
    return {o_ptw_gnt, o_ptw_done, o_icache_gnt, o_icache_done,
            o_dcache_gnt, o_dcache_done, o_ext_rden, o_ext_wren,
            o_ext_burst_vld, o_ext_burst_start, o_ext_burst_end,
            o_busy, o_err, |o_ext_paddr, |o_ext_burst, |o_ext_mask,
            |o_ext_wdat, |o_ptw_dat, |o_icache_dat, |o_dcache_dat};
  endfunction

  function automatic logic [2:0] gnts();
    return {o_ptw_gnt, o_icache_gnt, o_dcache_gnt};
  endfunction

  // who: 1 = ICACHE, 2 = DCACHE; entered in the IDLE cycle of the grant
  task automatic rd_line(input int who, input logic [31:0] tag,
                         input logic [AW-1:0] adr);
    logic [511:0] got;
    chk("rr_gnt", gnts(), (who == 1) ? 3'b010 : 3'b001);
    cyc(); #1;
    chk("rd_cmd", {o_ext_rden, o_ext_wren, o_ext_burst, o_ext_paddr},
        {2'b10, 3'd4, adr});
    for (int k = 0; k < 4; k++) begin
      cyc();
      i_ext_rd_ack = 1'b1;
      i_ext_rdat = beat(tag, k);
    end
    cyc();
    i_ext_rd_ack = 1'b0;
    #1;
    got = (who == 1) ? o_icache_dat : o_dcache_dat;
    chk("rd_done", {o_icache_done, o_dcache_done},
        (who == 1) ? 2'b10 : 2'b01);
    chk("rd_line", got, line(tag));
  endtask

  initial begin
    int nb;
    int n;
    logic seen;
    logic rdy_t;

    tv[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
    tv[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100};
    tv[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100};
    tv[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b010};
    tv[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001};
    tv[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001};
    tv[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000};
    tv[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'b001};
    tv[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b001};
    tv[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b100};

    repeat (3) cyc();
    #1;
    chk("reset_outs", outs(), '0);
    cyc();
    rst_n = 1'b1;

    // arbitration from reset: inputs removed before the next edge
    for (int i = 0; i < 10; i++) begin
      cyc();
      {i_ptw_req, i_icache_req, i_dcache_rden, i_dcache_wren, i_flush} =
        {tv[i].ptw, tv[i].ic, tv[i].dr, tv[i].dw, tv[i].fl};
      #1;
      chk($sformatf("arb%0d", i), gnts(), tv[i].gnt);
      {i_ptw_req, i_icache_req, i_dcache_rden, i_dcache_wren, i_flush} = '0;
    end
    cyc(); #1;
    chk("arb_idle", {o_busy, o_ext_rden}, 2'b00);

    // PTW beats ICACHE, single beat
    i_ptw_req = 1'b1;
    i_ptw_paddr = 34'h2_1234_5670;
    i_icache_req = 1'b1;
    i_icache_paddr = 34'h1_0000_0040;
    i_ext_rdy = 1'b1;
    #1;
    chk("ptw_gnt", gnts(), 3'b100);
    cyc();
    i_ptw_req = 1'b0;
    #1;
    chk("ptw_cmd", {o_ext_rden, o_ext_wren, o_ext_burst, o_ext_paddr},
        {2'b10, 3'd1, 34'h2_1234_5670});
    cyc();
    i_ext_rd_ack = 1'b1;
    i_ext_rdat = {4{32'hA5A5_A5A5}};
    cyc();
    i_ext_rd_ack = 1'b0;
    i_dcache_rden = 1'b1;
    i_dcache_paddr = 34'h3_0000_0080;
    #1;
    chk("ptw_done", {o_ptw_done, o_busy}, 2'b10);
    chk("ptw_dat", o_ptw_dat, {4{32'hA5A5_A5A5}});

    // ICACHE and DCACHE held: I, D, I, D
    rd_line(1, 32'h1100_0000, 34'h1_0000_0040);
    rd_line(2, 32'h2200_0000, 34'h3_0000_0080);
    rd_line(1, 32'h3300_0000, 34'h1_0000_0040);
    rd_line(2, 32'h4400_0000, 34'h3_0000_0080);
    i_icache_req = 1'b0;
    i_dcache_rden = 1'b0;
    chk("ic_dat_hold", o_icache_dat, line(32'h3300_0000));

    // writeback with rd+wr both set, rdy toggling
    cyc();
    i_dcache_wren = 1'b1;
    i_dcache_rden = 1'b1;
    i_dcache_paddr = 34'h0_8000_0100;
    i_dcache_wdat = line(32'h5000_0000);
    i_dcache_wmask = '1;
    i_ext_rdy = 1'b1;
    #1;
    chk("wr_gnt", gnts(), 3'b001);
    cyc();
    i_dcache_wren = 1'b0;
    i_dcache_rden = 1'b0;
    #1;
    chk("wr_cmd", {o_ext_rden, o_ext_wren, o_ext_burst, o_ext_paddr},
        {2'b01, 3'd4, 34'h0_8000_0100});
    nb = 0;
    rdy_t = 1'b0;
    for (int c = 0; c < 20 && nb < 4; c++) begin
      cyc();
      i_ext_rdy = rdy_t;
      rdy_t = ~rdy_t;
      #1;
      if (o_ext_burst_vld && i_ext_rdy) begin
        chk($sformatf("wr_beat%0d", nb),
            {o_ext_burst_start, o_ext_burst_end, o_ext_mask, o_ext_wdat},
            {nb == 0, nb == 3, 16'hFFFF, beat(32'h5000_0000, nb)});
        nb++;
      end
    end
    chk("wr_nbeats", nb, 4);
    cyc();
    i_ext_rdy = 1'b0;
    #1;
    chk("wr_resp_wait", {o_ext_burst_vld, o_dcache_done, o_busy}, 3'b001);
    cyc();
    i_ext_wr_ack = 1'b1;
    cyc();
    i_ext_wr_ack = 1'b0;
    #1;
    chk("wr_done", {o_dcache_done, o_busy}, 2'b10);

    // flush during ICACHE beat 2
    cyc();
    i_icache_req = 1'b1;
    i_icache_paddr = 34'h1_0000_0200;
    i_ext_rdy = 1'b1;
    #1;
    chk("fl_gnt", gnts(), 3'b010);
    cyc();
    i_icache_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      i_ext_rd_ack = 1'b1;
      i_ext_rdat = beat(32'h6600_0000, k);
      i_flush = (k == 2);
      #1;
      if (k == 3) chk("fl_busy_b3", o_busy, 1'b1);
    end
    cyc();
    i_ext_rd_ack = 1'b0;
    #1;
    chk("fl_nodone", {o_icache_done, o_busy}, 2'b00);

    // rdy stuck low in CMD
    cyc();
    i_ptw_req = 1'b1;
    i_ptw_paddr = 34'h0_0000_1000;
    i_ext_rdy = 1'b0;
    #1;
    chk("tmo_gnt", gnts(), 3'b100);
    cyc();
    i_ptw_req = 1'b0;
    n = 0;
    seen = 1'b0;
    for (int c = 0; c < 400; c++) begin
      #1;
      if (o_err) begin
        seen = 1'b1;
        break;
      end
      if (o_ext_rden) n++;
      cyc();
    end
    chk("tmo_seen", seen, 1'b1);
    chk("tmo_cycles", n, 255);
    chk("tmo_idle", {o_busy, o_ext_rden, o_ptw_done}, 3'b000);
    cyc(); #1;
    chk("tmo_pulse", o_err, 1'b0);

    // reset in the middle of an ICACHE read
    cyc();
    i_icache_req = 1'b1;
    i_icache_paddr = 34'h1_0000_0400;
    i_ext_rdy = 1'b1;
    #1;
    chk("rst_gnt", gnts(), 3'b010);
    cyc();
    i_icache_req = 1'b0;
    cyc();
    i_ext_rd_ack = 1'b1;
    i_ext_rdat = beat(32'h7700_0000, 0);
    cyc();
    i_ext_rdat = beat(32'h7700_0000, 1);
    rst_n = 1'b0;
    cyc(); #1;
    chk("rst_outs", outs(), '0);
    cyc();
    rst_n = 1'b1;
    for (int k = 2; k < 5; k++) begin
      cyc();
      i_ext_rdat = beat(32'h7700_0000, k);
    end
    cyc();
    i_ext_rd_ack = 1'b0;
    #1;
    chk("rst_ack_ignored", {o_busy, o_icache_done, o_err, |o_icache_dat},
        4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
